// File: rtl/dependency_check_pkg.sv
// Shared types and constants for the instruction-stream hazard checker.
package dependency_check_pkg;

    localparam int unsigned FIELD_W       = 4;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned ADDR_W        = 6;
    localparam int unsigned IDX_W         = 4;

    typedef logic [FIELD_W-1:0] field_t;

    localparam field_t OP_ADD = FIELD_W'(0);
    localparam field_t OP_SUB = FIELD_W'(1);
    localparam field_t OP_MUL = FIELD_W'(2);
    localparam field_t OP_DIV = FIELD_W'(3);
    localparam field_t OP_END = FIELD_W'(4);

    // Full instruction record as laid out in memory.
    typedef struct packed {
        field_t opcode;
        field_t rd;
        field_t rs1;
        field_t rs2;
    } instr_t;

    // Register fields only; the opcode never takes part in hazard detection.
    typedef struct packed {
        field_t rd;
        field_t rs1;
        field_t rs2;
    } regs_t;

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        FETCH3,
        DONE
    } state_t;

    // Every opcode from END upwards terminates the stream.
    function automatic logic is_end(input field_t op);
        return op >= OP_END;
    endfunction

endpackage

// File: rtl/dependency_check_hazard_compare.sv
// Compares the new instruction against one window entry.
// Ports: new_i (new instruction registers), old_i / old_valid_i (window
// entry and its valid bit), raw_c / war_c / waw_c (combinational flags).
module hazard_compare
    import dependency_check_pkg::*;
(
    input  regs_t new_i,
    input  regs_t old_i,
    input  logic  old_valid_i,
    output logic  raw_c,
    output logic  war_c,
    output logic  waw_c
);

    assign raw_c = old_valid_i && ((new_i.rs1 == old_i.rd) || (new_i.rs2 == old_i.rd));
    assign war_c = old_valid_i && ((new_i.rd == old_i.rs1) || (new_i.rd == old_i.rs2));
    assign waw_c = old_valid_i && (new_i.rd == old_i.rd);

endmodule

// File: rtl/dependency_check.sv
// Walks nibble-addressed instruction memory from address 0, decodes
// 4-nibble instructions and reports RAW/WAR/WAW hazards against the
// previous DEPTH instructions. Stops at an END opcode or end of memory.
// Ports: clk, rst (sync, active-high); address/send (memory port);
// report_valid, instr_idx, raw, war, waw (per-instruction report); done.
module dependency_check
    import dependency_check_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   address,
    input  logic [FIELD_W-1:0]  send,
    output logic                report_valid,
    output logic [IDX_W-1:0]    instr_idx,
    output logic [DEPTH-1:0]    raw,
    output logic [DEPTH-1:0]    war,
    output logic [DEPTH-1:0]    waw,
    output logic                done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    field_t              rd_q, rd_d;
    field_t              rs1_q, rs1_d;
    regs_t [DEPTH-1:0]   win_q, win_d;
    logic [DEPTH-1:0]    win_vld_q, win_vld_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic                report_valid_q, report_valid_d;
    logic [IDX_W-1:0]    instr_idx_q, instr_idx_d;
    logic [DEPTH-1:0]    raw_q, raw_d;
    logic [DEPTH-1:0]    war_q, war_d;
    logic [DEPTH-1:0]    waw_q, waw_d;
    logic                done_q, done_d;

    regs_t               new_c;
    logic [DEPTH-1:0]    raw_c, war_c, waw_c;

    // The instruction being completed; rs2 comes straight off the memory bus.
    always_comb begin
        new_c     = '0;
        new_c.rd  = rd_q;
        new_c.rs1 = rs1_q;
        new_c.rs2 = send;
    end

    // Entry k of the window is the instruction k+1 positions earlier.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_compare u_cmp (
            .new_i       (new_c),
            .old_i       (win_q[k]),
            .old_valid_i (win_vld_q[k]),
            .raw_c       (raw_c[k]),
            .war_c       (war_c[k]),
            .waw_c       (waw_c[k])
        );
    end

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        address_d      = address_q;
        rd_d           = rd_q;
        rs1_d          = rs1_q;
        win_d          = win_q;
        win_vld_d      = win_vld_q;
        count_d        = count_q;
        report_valid_d = 1'b0;
        instr_idx_d    = instr_idx_q;
        raw_d          = raw_q;
        war_d          = war_q;
        waw_d          = waw_q;
        done_d         = done_q;

        case (state_q)
            FETCH0: begin
                // Address still advances on the END fetch, then freezes.
                address_d = address_q + ADDR_W'(1);
                if (is_end(send)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH1;
                end
            end
            FETCH1: begin
                rd_d      = send;
                address_d = address_q + ADDR_W'(1);
                state_d   = FETCH2;
            end
            FETCH2: begin
                rs1_d     = send;
                address_d = address_q + ADDR_W'(1);
                state_d   = FETCH3;
            end
            FETCH3: begin
                report_valid_d = 1'b1;
                instr_idx_d    = count_q;
                raw_d          = raw_c;
                war_d          = war_c;
                waw_d          = waw_c;
                win_d          = {win_q[DEPTH-2:0], new_c};
                win_vld_d      = {win_vld_q[DEPTH-2:0], 1'b1};
                if (count_q == '1) begin
                    // Last slot of memory: address saturates instead of wrapping.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    count_d   = count_q + IDX_W'(1);
                    address_d = address_q + ADDR_W'(1);
                    state_d   = FETCH0;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = FETCH0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH0;
            address_q      <= '0;
            rd_q           <= '0;
            rs1_q          <= '0;
            win_q          <= '0;
            win_vld_q      <= '0;
            count_q        <= '0;
            report_valid_q <= 1'b0;
            instr_idx_q    <= '0;
            raw_q          <= '0;
            war_q          <= '0;
            waw_q          <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            address_q      <= address_d;
            rd_q           <= rd_d;
            rs1_q          <= rs1_d;
            win_q          <= win_d;
            win_vld_q      <= win_vld_d;
            count_q        <= count_d;
            report_valid_q <= report_valid_d;
            instr_idx_q    <= instr_idx_d;
            raw_q          <= raw_d;
            war_q          <= war_d;
            waw_q          <= waw_d;
            done_q         <= done_d;
        end
    end

    assign address      = address_q;
    assign report_valid = report_valid_q;
    assign instr_idx    = instr_idx_q;
    assign raw          = raw_q;
    assign war          = war_q;
    assign waw          = waw_q;
    assign done         = done_q;

endmodule

// File: tb/tb_dependency_check.sv
// Self-checking bench for dependency_check: directed and random programs,
// every cycle compared against a behavioural model of the report stream.
module tb_dependency_check;
    import dependency_check_pkg::*;

    localparam int unsigned D = 4;
    localparam int RUN_CYC   = 72;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   address;
    logic [3:0]   send;
    logic         report_valid;
    logic [3:0]   instr_idx;
    logic [D-1:0] raw, war, waw;
    logic         done;

    logic [3:0]   mem [64];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model results.
    int e_len;
    int m_raw [16];
    int m_war [16];
    int m_waw [16];

    always #5 clk = ~clk;

    always_comb send = mem[address];

    dependency_check #(.DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .send         (send),
        .report_valid (report_valid),
        .instr_idx    (instr_idx),
        .raw          (raw),
        .war          (war),
        .waw          (waw),
        .done         (done)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int n, input int op, input int rd, input int rs1, input int rs2);
        mem[4*n]   = 4'(op);
        mem[4*n+1] = 4'(rd);
        mem[4*n+2] = 4'(rs1);
        mem[4*n+3] = 4'(rs2);
    endtask

    // Program length and per-instruction hazard vectors straight from the rules.
    task automatic build_model();
        e_len = 16;
        for (int n = 15; n >= 0; n--)
            if (mem[4*n] >= 4'd4) e_len = n;
        for (int n = 0; n < 16; n++) begin
            m_raw[n] = 0;
            m_war[n] = 0;
            m_waw[n] = 0;
            for (int d = 1; d <= int'(D); d++) begin
                int j;
                j = n - d;
                if (j >= 0) begin
                    if (mem[4*n+2] == mem[4*j+1] || mem[4*n+3] == mem[4*j+1]) m_raw[n] |= (1 << (d-1));
                    if (mem[4*n+1] == mem[4*j+2] || mem[4*n+1] == mem[4*j+3]) m_war[n] |= (1 << (d-1));
                    if (mem[4*n+1] == mem[4*j+1])                             m_waw[n] |= (1 << (d-1));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Checks cycles 0..ncyc-1 after reset release, sampled on the falling edge.
    task automatic run_cycles(input string name, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int ea, erv, edone, last;
            int eidx, eraw, ewar, ewaw;
            @(negedge clk);
            if (e_len < 16) begin
                ea    = (c < 4*e_len+1) ? c : 4*e_len+1;
                edone = (c >= 4*e_len+1) ? 1 : 0;
            end else begin
                ea    = (c < 63) ? c : 63;
                edone = (c >= 64) ? 1 : 0;
            end
            erv  = (c >= 4 && (c % 4) == 0 && (c/4 - 1) < e_len) ? 1 : 0;
            last = -1;
            if (c >= 4 && e_len >= 1) last = (c/4 - 1 < e_len - 1) ? c/4 - 1 : e_len - 1;
            eidx = (last >= 0) ? last : 0;
            eraw = (last >= 0) ? m_raw[last] : 0;
            ewar = (last >= 0) ? m_war[last] : 0;
            ewaw = (last >= 0) ? m_waw[last] : 0;
            chk($sformatf("%s c%0d address", name, c), 32'(address), 32'(ea));
            chk($sformatf("%s c%0d report_valid", name, c), 32'(report_valid), 32'(erv));
            chk($sformatf("%s c%0d instr_idx", name, c), 32'(instr_idx), 32'(eidx));
            chk($sformatf("%s c%0d raw", name, c), 32'(raw), 32'(eraw));
            chk($sformatf("%s c%0d war", name, c), 32'(war), 32'(ewar));
            chk($sformatf("%s c%0d waw", name, c), 32'(waw), 32'(ewaw));
            chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(edone));
        end
    endtask

    task automatic load_plan_program();
        for (int i = 0; i < 64; i++) mem[i] = 4'd0;
        put(0, OP_ADD, 5, 0, 1);
        put(1, OP_MUL, 6, 2, 5);
        put(2, OP_SUB, 5, 3, 6);
        put(3, OP_DIV, 6, 5, 4);
        put(4, OP_ADD, 1, 5, 6);
        put(5, OP_SUB, 2, 1, 1);
        put(6, OP_MUL, 3, 2, 1);
        put(7, OP_END, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'd0;

        // Directed: hazard chain then END at address 28.
        load_plan_program();
        build_model();
        do_reset();
        run_cycles("plan", RUN_CYC);

        // Directed: 16 instructions all writing R1, no END.
        for (int n = 0; n < 16; n++) put(n, int'($urandom_range(0, 3)), 1, 2, 3);
        build_model();
        do_reset();
        run_cycles("allr1", RUN_CYC);

        // Directed: reset asserted in cycle 10, then a full restart.
        load_plan_program();
        build_model();
        do_reset();
        run_cycles("prereset", 11);
        do_reset();
        run_cycles("postreset", RUN_CYC);

        // Random programs, small register set to provoke hazards.
        for (int p = 0; p < 8; p++) begin
            for (int n = 0; n < 16; n++) begin
                int op;
                op = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
                put(n, op, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            end
            if (p == 0) mem[0] = 4'd9;
            build_model();
            do_reset();
            run_cycles($sformatf("rand%0d", p), RUN_CYC);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
